// File: rtl/dtm_jtag_v013.sv
// RISC-V Debug 0.13 JTAG DTM: TAP controller, IDCODE/DTMCS/DMI/BYPASS registers,
// and a single-outstanding valid/ready DMI bridge with sticky status and hard-reset discard.
module dtm_jtag_v013 #(
  parameter int          IR_BITS       = 5,
  parameter int          ABITS         = 7,
  parameter logic [2:0]  IDLE_CYCLES   = 3'd5,
  parameter logic [3:0]  JTAG_VERSION  = 4'h1,
  parameter logic [15:0] JTAG_PART_NUM = 16'h0E31,
  parameter logic [10:0] JTAG_MANUF_ID = 11'h489
) (
  input  logic             jtag_TCK,
  input  logic             jtag_TRST,
  input  logic             jtag_TMS,
  input  logic             jtag_TDI,
  output logic             jtag_TDO,
  output logic             jtag_DRV_TDO,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS+33:0] dmi_req_bits,
  input  logic             dmi_resp_valid,
  output logic             dmi_resp_ready,
  input  logic [33:0]      dmi_resp_bits,
  output logic [7:0]       busy_retry_count
);

  localparam int DW = ABITS + 34;

  localparam logic [3:0] TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
                         SH_DR  = 4'd4,  EX1_DR = 4'd5,  PA_DR  = 4'd6,  EX2_DR = 4'd7,
                         UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
                         EX1_IR = 4'd12, PA_IR  = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15;

  localparam logic [IR_BITS-1:0] IR_IDCODE = IR_BITS'(5'h01);
  localparam logic [IR_BITS-1:0] IR_DTMCS  = IR_BITS'(5'h10);
  localparam logic [IR_BITS-1:0] IR_DMI    = IR_BITS'(5'h11);

  logic [3:0]         r_state, w_state_nxt;
  logic [IR_BITS-1:0] r_ir, r_ir_sh;
  logic [DW-1:0]      r_shift, w_shift_nxt, w_shift_dn, w_cap_val, w_dmi_cap;
  logic [DW-1:0]      r_req_bits;
  logic               r_req_valid, r_outstanding, r_sticky_fail, r_sticky_busy, r_discard;
  logic [7:0]         r_busy_cnt;
  logic               r_tdo, r_drv;
  logic               w_sel_idcode, w_sel_dtmcs, w_sel_dmi;
  int                 w_dr_len;
  logic [1:0]         w_dmistat;
  logic [31:0]        w_idcode, w_dtmcs;
  logic               w_busy, w_cap_dmi, w_upd_dmi, w_upd_dtmcs, w_resp_fire, w_resp_ready;

  // TAP state graph
  always_comb begin
    w_state_nxt = TLR;
    case (r_state)
      TLR:    w_state_nxt = jtag_TMS ? TLR    : RTI;
      RTI:    w_state_nxt = jtag_TMS ? SEL_DR : RTI;
      SEL_DR: w_state_nxt = jtag_TMS ? SEL_IR : CAP_DR;
      CAP_DR: w_state_nxt = jtag_TMS ? EX1_DR : SH_DR;
      SH_DR:  w_state_nxt = jtag_TMS ? EX1_DR : SH_DR;
      EX1_DR: w_state_nxt = jtag_TMS ? UPD_DR : PA_DR;
      PA_DR:  w_state_nxt = jtag_TMS ? EX2_DR : PA_DR;
      EX2_DR: w_state_nxt = jtag_TMS ? UPD_DR : SH_DR;
      UPD_DR: w_state_nxt = jtag_TMS ? SEL_DR : RTI;
      SEL_IR: w_state_nxt = jtag_TMS ? TLR    : CAP_IR;
      CAP_IR: w_state_nxt = jtag_TMS ? EX1_IR : SH_IR;
      SH_IR:  w_state_nxt = jtag_TMS ? EX1_IR : SH_IR;
      EX1_IR: w_state_nxt = jtag_TMS ? UPD_IR : PA_IR;
      PA_IR:  w_state_nxt = jtag_TMS ? EX2_IR : PA_IR;
      EX2_IR: w_state_nxt = jtag_TMS ? UPD_IR : SH_IR;
      UPD_IR: w_state_nxt = jtag_TMS ? SEL_DR : RTI;
      default: w_state_nxt = TLR;
    endcase
  end

  assign w_sel_idcode = (r_ir == IR_IDCODE);
  assign w_sel_dtmcs  = (r_ir == IR_DTMCS);
  assign w_sel_dmi    = (r_ir == IR_DMI);

  assign w_dmistat = r_sticky_fail ? 2'd2 : (r_sticky_busy ? 2'd3 : 2'd0);
  assign w_idcode  = {JTAG_VERSION, JTAG_PART_NUM, JTAG_MANUF_ID, 1'b1};
  assign w_dtmcs   = {14'b0, 1'b0, 1'b0, 1'b0, IDLE_CYCLES, w_dmistat, 6'(ABITS), 4'h1};

  // Discard pending counts as busy so the host retries until the stale response is gone
  assign w_busy      = (r_outstanding & ~dmi_resp_valid) | r_sticky_busy | r_discard;
  assign w_cap_dmi   = (r_state == CAP_DR) & w_sel_dmi;
  assign w_upd_dmi   = (r_state == UPD_DR) & w_sel_dmi;
  assign w_upd_dtmcs = (r_state == UPD_DR) & w_sel_dtmcs;

  assign w_resp_ready = ~jtag_TRST & (r_discard | (w_cap_dmi & ~w_busy & dmi_resp_valid));
  assign w_resp_fire  = dmi_resp_valid & w_resp_ready;

  always_comb begin
    if (w_busy)              w_dmi_cap = DW'(2'b11);
    else if (dmi_resp_valid) w_dmi_cap = {r_req_bits[DW-1:34], dmi_resp_bits};
    else                     w_dmi_cap = {r_req_bits[DW-1:34], 32'b0, w_dmistat};
  end

  always_comb begin
    if (w_sel_idcode)     w_cap_val = DW'(w_idcode);
    else if (w_sel_dtmcs) w_cap_val = DW'(w_dtmcs);
    else if (w_sel_dmi)   w_cap_val = w_dmi_cap;
    else                  w_cap_val = '0;
  end

  always_comb begin
    if (w_sel_idcode || w_sel_dtmcs) w_dr_len = 32;
    else if (w_sel_dmi)              w_dr_len = DW;
    else                             w_dr_len = 1;
  end

  // TDI enters at the top of the selected register; bits above it stay zero
  assign w_shift_dn = {1'b0, r_shift[DW-1:1]};
  always_comb begin
    w_shift_nxt = '0;
    for (int i = 0; i < DW; i++) begin
      if (i == w_dr_len - 1)     w_shift_nxt[i] = jtag_TDI;
      else if (i < w_dr_len - 1) w_shift_nxt[i] = w_shift_dn[i];
    end
  end

  always_ff @(posedge jtag_TCK) begin
    if (jtag_TRST) begin
      r_state <= TLR;
      r_ir    <= IR_IDCODE;
      r_ir_sh <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        TLR:    r_ir    <= IR_IDCODE;
        CAP_IR: r_ir_sh <= IR_BITS'(2'b01);
        SH_IR:  r_ir_sh <= {jtag_TDI, r_ir_sh[IR_BITS-1:1]};
        UPD_IR: r_ir    <= r_ir_sh;
        CAP_DR: r_shift <= w_cap_val;
        SH_DR:  r_shift <= w_shift_nxt;
        default: ;
      endcase
    end
  end

  always_ff @(posedge jtag_TCK) begin
    if (jtag_TRST) begin
      r_req_valid   <= 1'b0;
      r_req_bits    <= '0;
      r_outstanding <= 1'b0;
      r_sticky_fail <= 1'b0;
      r_sticky_busy <= 1'b0;
      r_discard     <= 1'b0;
      r_busy_cnt    <= 8'd0;
    end else begin
      if (r_req_valid && dmi_req_ready) r_req_valid <= 1'b0;
      if (w_resp_fire) begin
        r_outstanding <= 1'b0;
        r_discard     <= 1'b0;
      end
      if (w_cap_dmi) begin
        if (w_busy) begin
          r_sticky_busy <= 1'b1;
          if (r_busy_cnt != 8'hFF) r_busy_cnt <= r_busy_cnt + 8'd1;
        end else if (dmi_resp_valid && dmi_resp_bits[1:0] != 2'b00) begin
          r_sticky_fail <= 1'b1;
        end
      end
      // only read (1) and write (2) launch a transaction
      if (w_upd_dmi && w_dmistat == 2'd0 && (^r_shift[1:0]) && !r_outstanding && !r_discard) begin
        r_req_bits    <= r_shift;
        r_req_valid   <= 1'b1;
        r_outstanding <= 1'b1;
      end
      if (w_upd_dtmcs) begin
        if (r_shift[16] || r_shift[17]) begin
          r_sticky_fail <= 1'b0;
          r_sticky_busy <= 1'b0;
        end
        if (r_shift[17]) begin
          r_req_valid   <= 1'b0;
          r_outstanding <= 1'b0;
          r_discard     <= r_outstanding & ~w_resp_fire;
        end
      end
    end
  end

  always_ff @(negedge jtag_TCK) begin
    if (jtag_TRST) begin
      r_tdo <= 1'b0;
      r_drv <= 1'b0;
    end else begin
      r_drv <= (r_state == SH_IR) || (r_state == SH_DR);
      r_tdo <= (r_state == SH_IR) ? r_ir_sh[0] : (r_state == SH_DR) ? r_shift[0] : 1'b0;
    end
  end

  assign jtag_TDO         = r_tdo;
  assign jtag_DRV_TDO     = r_drv;
  assign dmi_req_valid    = r_req_valid;
  assign dmi_req_bits     = r_req_bits;
  assign dmi_resp_ready   = w_resp_ready;
  assign busy_retry_count = r_busy_cnt;

endmodule
